// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared mode encodings and round-robin pick helper for gray_conv_arbiter
package gray_conv_pkg;
  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;
  localparam int MAX_N = 8;
  function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] valid, input logic [2:0] ptr, input int n);
    logic [MAX_N-1:0] g;
    int idx;
    g = '0;
    for (int k = MAX_N - 1; k >= 0; k--)
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (valid[idx]) g = MAX_N'(1) << idx;
      end
    return g;
  endfunction
endpackage

// File: rtl/bin_gray_unit.sv
// bin_gray_unit: combinational binary<->Gray converter (in, mode) -> out, mode 0 = bin->gray, 1 = gray->bin
module bin_gray_unit
  import gray_conv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] in,
  input  logic         mode,
  output logic [W-1:0] out
);
  logic [W-1:0] b;
  always_comb begin
    b = in;
    for (int k = W - 2; k >= 0; k--) b[k] = b[k+1] ^ in[k];
  end
  assign out = (mode == MODE_G2B) ? b : in ^ (in >> 1);
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin shared binary<->Gray converter with registered valid/ready response; ports req_valid/req_mode/req_data/req_ready in, rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_mode out
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_mode,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_mode
);
  logic [IDW-1:0] rr_ptr, gid, nxt_ptr;
  logic [N-1:0] grant;
  logic [W-1:0] op, conv;
  logic slot_free, gmode, accept;
  assign slot_free = !rsp_valid | rsp_ready;
  assign grant = N'(rr_pick(MAX_N'(req_valid), 3'(rr_ptr), N));
  // grant is forced off while reset is held so nothing is accepted during reset
  assign req_ready = (slot_free && rst_n) ? grant : '0;
  assign accept = |req_ready;
  always_comb begin
    gid = '0;
    for (int i = 0; i < N; i++) if (grant[i]) gid = IDW'(i);
  end
  assign op = req_data[gid*W +: W];
  assign gmode = req_mode[gid];
  assign nxt_ptr = (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;
  bin_gray_unit #(.W(W)) u_cvt (.in(op), .mode(gmode), .out(conv));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_mode  <= 1'b0;
      rr_ptr    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= conv;
      rsp_id    <= gid;
      rsp_mode  <= gmode;
      rr_ptr    <= nxt_ptr;
    end else if (rsp_ready) rsp_valid <= 1'b0;
endmodule
